// File: rtl/pc_restore_if.sv
// Request, stack-read and restore-result signals of the PC restore unit.
// master = decode/memory environment side, slave = pc_restore_unit.
interface pc_restore_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32
);
  logic              start;
  logic              is_rti;
  logic              flush;
  logic [DATA_W-1:0] sp_in;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_valid;
  logic              busy;
  logic [PC_W-1:0]   pc_out;
  logic              pc_load;
  logic [DATA_W-1:0] flags_out;
  logic              flags_load;
  logic [DATA_W-1:0] sp_out;
  logic              sp_we;
  logic              underflow;

  modport master (
    output start, is_rti, flush, sp_in, mem_rd_data, mem_rd_valid,
    input  mem_rd_en, mem_addr, busy, pc_out, pc_load, flags_out,
           flags_load, sp_out, sp_we, underflow
  );

  modport slave (
    input  start, is_rti, flush, sp_in, mem_rd_data, mem_rd_valid,
    output mem_rd_en, mem_addr, busy, pc_out, pc_load, flags_out,
           flags_load, sp_out, sp_we, underflow
  );
endinterface

// File: rtl/pc_restore_unit.sv
// Pops a RET (2 words) or RTI (3 words) context frame off the data stack and
// loads PC/flags/SP. Optional feature macro: STACK_UNDERFLOW_CHECK_EN.
module pc_restore_unit #(
  parameter int                DATA_W = 16,
  parameter int                PC_W   = 32,
  parameter logic [DATA_W-1:0] SP_TOP = {DATA_W{1'b1}}
) (
  input  logic        clk,
  input  logic        reset,
  pc_restore_if.slave bus,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: start is a pulse taken only while busy=0 (no queueing);
  // each mem_rd_en pulse is answered by exactly one mem_rd_valid pulse,
  // which is only consumed in WAIT.
  localparam int FRAME_W = 3 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   sp_q;
  logic [DATA_W-1:0]   addr_q;
  logic [FRAME_W-1:0]  frame_q;
  logic                rti_q;
  logic [1:0]          total_q;
  logic [1:0]          count_q;
  logic                busy_q;
  logic                rd_en_q;
  logic                pc_load_q;
  logic                flags_load_q;
  logic                sp_we_q;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   flags_q;
  logic [DATA_W-1:0]   sp_out_q;

  logic [FRAME_W-1:0]  frame_d;
  logic [DATA_W-1:0]   sp_inc;
  logic [DATA_W-1:0]   sp_in_inc;
  logic                start_blk;
  logic                next_blk;

  assign frame_d   = {frame_q[FRAME_W-DATA_W-1:0], bus.mem_rd_data};
  assign sp_inc    = sp_q + DATA_W'(1);
  assign sp_in_inc = bus.sp_in + DATA_W'(1);

`ifdef STACK_UNDERFLOW_CHECK_EN
  logic underflow_q;

  // A pop above SP_TOP, or one whose increment wraps, would read outside the stack.
  function automatic logic pop_blocked(input logic [DATA_W-1:0] sp);
    logic [DATA_W:0] nxt;
    nxt = {1'b0, sp} + (DATA_W+1)'(1);
    return nxt[DATA_W] || (nxt > {1'b0, SP_TOP});
  endfunction

  assign start_blk     = pop_blocked(bus.sp_in);
  assign next_blk      = pop_blocked(sp_q);
  assign bus.underflow = underflow_q;
`else
  assign start_blk     = 1'b0;
  assign next_blk      = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sp_q         <= '0;
      addr_q       <= '0;
      frame_q      <= '0;
      rti_q        <= 1'b0;
      total_q      <= 2'd0;
      count_q      <= 2'd0;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      pc_load_q    <= 1'b0;
      flags_load_q <= 1'b0;
      sp_we_q      <= 1'b0;
      pc_q         <= '0;
      flags_q      <= '0;
      sp_out_q     <= '0;
`ifdef STACK_UNDERFLOW_CHECK_EN
      underflow_q  <= 1'b0;
`endif
    end else begin
      rd_en_q      <= 1'b0;
      pc_load_q    <= 1'b0;
      flags_load_q <= 1'b0;
      sp_we_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            sp_q    <= bus.sp_in;
            rti_q   <= bus.is_rti;
            total_q <= bus.is_rti ? 2'd3 : 2'd2;
            count_q <= 2'd0;
            frame_q <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= ~start_blk;
            addr_q  <= sp_in_inc;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (next_blk) begin
`ifdef STACK_UNDERFLOW_CHECK_EN
            underflow_q <= 1'b1;
`endif
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            sp_q    <= sp_inc;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (bus.mem_rd_valid) begin
            frame_q <= frame_d;
            count_q <= count_q + 2'd1;
            if ((count_q + 2'd1) == total_q) begin
              // Outputs are registered so the strobes line up with DONE.
              pc_load_q    <= 1'b1;
              sp_we_q      <= 1'b1;
              pc_q         <= frame_d[PC_W-1:0];
              sp_out_q     <= sp_q;
              flags_load_q <= rti_q;
              if (rti_q) begin
                flags_q <= frame_d[FRAME_W-1:PC_W];
              end
              state_q <= S_DONE;
            end else begin
              rd_en_q <= ~next_blk;
              addr_q  <= sp_inc;
              state_q <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rd_en  = rd_en_q;
  assign bus.mem_addr   = addr_q;
  assign bus.busy       = busy_q;
  assign bus.pc_out     = pc_q;
  assign bus.pc_load    = pc_load_q;
  assign bus.flags_out  = flags_q;
  assign bus.flags_load = flags_load_q;
  assign bus.sp_out     = sp_out_q;
  assign bus.sp_we      = sp_we_q;
  assign dbg_state_o    = state_q;

endmodule
